// File: rtl/x2c_gbx_pkg.sv
// Shared constants for the x2c FIFO read gearbox: FSM encoding, descriptor
// field positions and datapath widths.
package x2c_gbx_pkg;

    localparam int BEAT_W  = 64;
    localparam int WORD_W  = 256;
    localparam int LANES   = 4;

    localparam int LEN_LSB = 0;
    localparam int LEN_MSB = 15;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_SFW  = 3'd2;
    localparam logic [2:0] ST_RDW  = 3'd3;
    localparam logic [2:0] ST_LOAD = 3'd4;
    localparam logic [2:0] ST_SEND = 3'd5;

    // Number of 256-bit payload words carrying len bytes.
    function automatic logic [15:0] words_for_len(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'd31;
        return {4'd0, sum[16:5]};
    endfunction

endpackage

// File: rtl/x2c_gbx_lane_mux.sv
// Holding register for one FIFO word, 4:1 beat select and sop/eop/mod
// framing derived from the byte count still to be sent.
module x2c_gbx_lane_mux
    import x2c_gbx_pkg::*;
(
    input  logic                clk,
    input  logic                reset_,
    input  logic                load,
    input  logic [WORD_W-1:0]   word_in,
    input  logic [1:0]          lane,
    input  logic                valid,
    input  logic                first,
    input  logic [15:0]         bytes_left,
    output logic [BEAT_W-1:0]   data,
    output logic                sop,
    output logic                eop,
    output logic [2:0]          mod
);

    logic [WORD_W-1:0] hold_q;
    logic [WORD_W-1:0] hold_d;
    logic [BEAT_W-1:0] lane_data [LANES];
    logic              last_beat;

    always_comb begin
        hold_d = load ? word_in : hold_q;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_data[gi] = hold_q[gi*BEAT_W +: BEAT_W];
        end
    endgenerate

    // A count of exactly 8 yields mod 0, which downstream reads as a full beat.
    always_comb begin
        data      = lane_data[lane];
        last_beat = (bytes_left <= 16'd8);
        sop       = valid & first;
        eop       = valid & last_beat;
        mod       = (valid & last_beat) ? bytes_left[2:0] : 3'd0;
    end

endmodule

// File: rtl/x2c_fifo_rd_gbx.sv
// Drains descriptor + payload words from the x2c data FIFO and emits framed
// 64-bit beats. Define X2C_GBX_STORE_FWD_EN to wait for a whole packet first.
module x2c_fifo_rd_gbx
    import x2c_gbx_pkg::*;
#(
    parameter logic [15:0] MAX_LEN = 16'd9600,
    parameter int          PTR     = 10
)
(
    input  logic                clk,
    input  logic                reset_,
    output logic                fifo_rdreq,
    input  logic [WORD_W-1:0]   fifo_q,
    input  logic                fifo_empty,
    input  logic [PTR:0]        fifo_usedw,
    output logic [BEAT_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                tx_sop,
    output logic                tx_eop,
    output logic [2:0]          tx_mod,
    output logic                err_len,
    output logic [31:0]         pkt_cnt
);

    logic [2:0]  state_q, state_d;
    logic [15:0] words_left_q, words_left_d;
    logic [15:0] bytes_left_q, bytes_left_d;
    logic [1:0]  lane_q, lane_d;
    logic        first_q, first_d;
    logic        err_len_q, err_len_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic        run_q;
    logic        load;
    logic [15:0] desc_len;

    assign desc_len = fifo_q[LEN_MSB:LEN_LSB];
    assign tx_valid = (state_q == ST_SEND);
    assign err_len  = err_len_q;
    assign pkt_cnt  = pkt_cnt_q;

`ifdef X2C_GBX_STORE_FWD_EN
    logic [31:0] usedw_ext;
    assign usedw_ext = 32'(fifo_usedw);
`else
    logic unused_usedw;
    assign unused_usedw = ^fifo_usedw;
`endif

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        bytes_left_d = bytes_left_q;
        lane_d       = lane_q;
        first_d      = first_q;
        pkt_cnt_d    = pkt_cnt_q;
        err_len_d    = 1'b0;
        fifo_rdreq   = 1'b0;
        load         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // run_q keeps the read side quiet during the cycle reset releases.
                if (run_q && !fifo_empty) begin
                    fifo_rdreq = 1'b1;
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                if (desc_len == 16'd0 || desc_len > MAX_LEN) begin
                    err_len_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    words_left_d = words_for_len(desc_len);
                    bytes_left_d = desc_len;
                    first_d      = 1'b1;
`ifdef X2C_GBX_STORE_FWD_EN
                    state_d      = ST_SFW;
`else
                    state_d      = ST_RDW;
`endif
                end
            end
`ifdef X2C_GBX_STORE_FWD_EN
            ST_SFW: begin
                if (usedw_ext >= 32'(words_left_q)) begin
                    state_d = ST_RDW;
                end
            end
`endif
            ST_RDW: begin
                if (!fifo_empty) begin
                    fifo_rdreq = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load         = 1'b1;
                words_left_d = words_left_q - 16'd1;
                lane_d       = 2'd0;
                state_d      = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    bytes_left_d = (bytes_left_q > 16'd8) ? (bytes_left_q - 16'd8) : 16'd0;
                    lane_d       = lane_q + 2'd1;
                    first_d      = 1'b0;
                    if (tx_eop) begin
                        pkt_cnt_d = pkt_cnt_q + 32'd1;
                        state_d   = ST_IDLE;
                    end else if (lane_q == 2'd3) begin
                        // Fetch the next word while the last lane leaves.
                        if (!fifo_empty) begin
                            fifo_rdreq = 1'b1;
                            state_d    = ST_LOAD;
                        end else begin
                            state_d    = ST_RDW;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q      <= ST_IDLE;
            words_left_q <= '0;
            bytes_left_q <= '0;
            lane_q       <= '0;
            first_q      <= 1'b0;
            err_len_q    <= 1'b0;
            pkt_cnt_q    <= '0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            bytes_left_q <= bytes_left_d;
            lane_q       <= lane_d;
            first_q      <= first_d;
            err_len_q    <= err_len_d;
            pkt_cnt_q    <= pkt_cnt_d;
            run_q        <= 1'b1;
        end
    end

    x2c_gbx_lane_mux u_lane_mux (
        .clk        (clk),
        .reset_     (reset_),
        .load       (load),
        .word_in    (fifo_q),
        .lane       (lane_q),
        .valid      (tx_valid),
        .first      (first_q),
        .bytes_left (bytes_left_q),
        .data       (tx_data),
        .sop        (tx_sop),
        .eop        (tx_eop),
        .mod        (tx_mod)
    );

endmodule

// File: tb/tb_x2c_fifo_rd_gbx.sv
// Bench for x2c_fifo_rd_gbx: FIFO model, byte-level packet model and a beat
// scoreboard; honours X2C_GBX_STORE_FWD_EN when defined.
`timescale 1ns/1ps
module tb_x2c_fifo_rd_gbx;

    localparam int PTR = 10;
    localparam int UW  = PTR + 1;

    logic           clk = 1'b0;
    logic           reset_ = 1'b0;
    logic           fifo_rdreq;
    logic [255:0]   fifo_q = '0;
    logic           fifo_empty = 1'b1;
    logic [PTR:0]   fifo_usedw = '0;
    logic [63:0]    tx_data;
    logic           tx_valid;
    logic           tx_ready = 1'b0;
    logic           tx_sop;
    logic           tx_eop;
    logic [2:0]     tx_mod;
    logic           err_len;
    logic [31:0]    pkt_cnt;

    x2c_fifo_rd_gbx #(.MAX_LEN(16'd9600), .PTR(PTR)) dut (
        .clk        (clk),
        .reset_     (reset_),
        .fifo_rdreq (fifo_rdreq),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty),
        .fifo_usedw (fifo_usedw),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_sop     (tx_sop),
        .tx_eop     (tx_eop),
        .tx_mod     (tx_mod),
        .err_len    (err_len),
        .pkt_cnt    (pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
    } beat_t;

    logic [255:0] fq[$];
    logic [255:0] push_q[$];
    beat_t        exp_q[$];
    int           acc_cyc[$];
    logic [7:0]   pkt_bytes[];

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int err_seen = 0;
    int stalls = 0;
    int exp_pkt = 0;

    logic        prev_stall = 1'b0;
    logic [63:0] prev_d = '0;
    logic        prev_sop = 1'b0;
    logic        prev_eop = 1'b0;
    logic [2:0]  prev_mod = '0;

    // Standard-read FIFO model: data appears the cycle after rdreq, flags update after the edge.
    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            fq.delete();
            push_q.delete();
            fifo_q     <= '0;
            fifo_empty <= 1'b1;
            fifo_usedw <= '0;
        end else begin
            cycle <= cycle + 1;
            if (fifo_rdreq && fq.size() > 0) fifo_q <= fq.pop_front();
            while (push_q.size() > 0) fq.push_back(push_q.pop_front());
            fifo_empty <= (fq.size() == 0);
            fifo_usedw <= UW'(fq.size());
        end
    end

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_) begin
            if (fifo_rdreq) begin
                checks++;
                if (fifo_empty) begin
                    failures++;
                    $display("FAIL rdreq_while_empty: rdreq=%b empty=%b want no read", fifo_rdreq, fifo_empty);
                end
            end
            if (err_len) err_seen++;
            if (prev_stall) begin
                stalls++;
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_d || tx_sop !== prev_sop ||
                    tx_eop !== prev_eop || tx_mod !== prev_mod) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%b d=%h sop=%b eop=%b mod=%0d want v=1 d=%h sop=%b eop=%b mod=%0d",
                             tx_valid, tx_data, tx_sop, tx_eop, tx_mod, prev_d, prev_sop, prev_eop, prev_mod);
                end
            end
            if (tx_valid && tx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: got d=%h sop=%b eop=%b want no beat", tx_data, tx_sop, tx_eop);
                end else begin
                    if (tx_data !== exp_q[0].d || tx_sop !== exp_q[0].sop || tx_eop !== exp_q[0].eop ||
                        (exp_q[0].eop && tx_mod !== exp_q[0].mod)) begin
                        failures++;
                        $display("FAIL beat: got d=%h sop=%b eop=%b mod=%0d want d=%h sop=%b eop=%b mod=%0d",
                                 tx_data, tx_sop, tx_eop, tx_mod, exp_q[0].d, exp_q[0].sop, exp_q[0].eop, exp_q[0].mod);
                    end
                    void'(exp_q.pop_front());
                end
                acc_cyc.push_back(cycle);
            end
            prev_stall <= tx_valid && !tx_ready;
            prev_d     <= tx_data;
            prev_sop   <= tx_sop;
            prev_eop   <= tx_eop;
            prev_mod   <= tx_mod;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    // Random payload bytes and the beats the specification implies for them.
    task automatic build_pkt(input int len);
        int    nw;
        int    nb;
        beat_t b;
        nw = (len + 31) / 32;
        nb = (len + 7) / 8;
        pkt_bytes = new[nw * 32];
        foreach (pkt_bytes[i]) pkt_bytes[i] = 8'($urandom);
        for (int i = 0; i < nb; i++) begin
            for (int k = 0; k < 8; k++) b.d[8*k +: 8] = pkt_bytes[8*i + k];
            b.sop = (i == 0);
            b.eop = (i == nb - 1);
            b.mod = 3'(len % 8);
            exp_q.push_back(b);
        end
    endtask

    task automatic push_desc(input int len);
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[32*k +: 32] = $urandom;
        w[15:0] = 16'(len);
        push_q.push_back(w);
    endtask

    task automatic push_words(input int first_w, input int last_w);
        logic [255:0] w;
        for (int wi = first_w; wi <= last_w; wi++) begin
            for (int b = 0; b < 32; b++) w[8*b +: 8] = pkt_bytes[32*wi + b];
            push_q.push_back(w);
        end
    endtask

    task automatic queue_pkt(input int len);
        build_pkt(len);
        push_desc(len);
        push_words(0, (len + 31) / 32 - 1);
    endtask

    // Mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready.
    task automatic wait_drain(input int budget, input int mode, output bit ok);
        int n;
        int ph;
        n  = 0;
        ph = 0;
        ok = 1'b0;
        while (n < budget) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !tx_valid) begin
                ok = 1'b1;
                break;
            end
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                default: tx_ready = ($urandom_range(0, 3) != 0);
            endcase
            ph++;
            n++;
        end
        tx_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_   = 1'b0;
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
        checks++;
        if (fifo_rdreq !== 1'b0) begin failures++; $display("FAIL reset_rdreq: got %b want 0", fifo_rdreq); end
        checks++;
        if (pkt_cnt !== 32'd0) begin failures++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
        checks++;
        if ({tx_sop, tx_eop, tx_mod, err_len, tx_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got sop=%b eop=%b mod=%0d err=%b d=%h want all 0",
                     tx_sop, tx_eop, tx_mod, err_len, tx_data);
        end
        reset_   = 1'b1;
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_two_words;
        bit ok;
        acc_cyc.delete();
        queue_pkt(64);
        wait_drain(300, 0, ok);
        exp_pkt++;
        checks++;
        if (!ok) begin failures++; $display("FAIL two_words_timeout: got %0d beats left want 0", exp_q.size()); end
        checks++;
        if (pkt_cnt !== 32'(exp_pkt)) begin failures++; $display("FAIL two_words_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); end
        checks++;
        if (acc_cyc.size() != 8) begin
            failures++;
            $display("FAIL two_words_beats: got %0d want 8", acc_cyc.size());
        end else begin
            checks++;
            if (acc_cyc[4] - acc_cyc[3] != 2) begin
                failures++;
                $display("FAIL two_words_bubble: got gap %0d want 2", acc_cyc[4] - acc_cyc[3]);
            end
            checks++;
            if (acc_cyc[3] - acc_cyc[0] != 3) begin
                failures++;
                $display("FAIL two_words_burst: got span %0d want 3", acc_cyc[3] - acc_cyc[0]);
            end
        end
    endtask

    task automatic test_short_last;
        bit ok;
        acc_cyc.delete();
        queue_pkt(45);
        queue_pkt(16);
        wait_drain(300, 0, ok);
        exp_pkt += 2;
        checks++;
        if (!ok) begin failures++; $display("FAIL short_last_timeout: got %0d beats left want 0", exp_q.size()); end
        checks++;
        if (acc_cyc.size() != 8) begin failures++; $display("FAIL short_last_beats: got %0d want 8", acc_cyc.size()); end
        checks++;
        if (pkt_cnt !== 32'(exp_pkt)) begin failures++; $display("FAIL short_last_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); end
    endtask

    task automatic test_bad_len;
        bit ok;
        int err0;
        err0 = err_seen;
        acc_cyc.delete();
        push_desc(0);
        push_desc(9601);
        queue_pkt(8);
        wait_drain(300, 0, ok);
        exp_pkt++;
        checks++;
        if (!ok) begin failures++; $display("FAIL bad_len_timeout: got %0d beats left want 0", exp_q.size()); end
        checks++;
        if (err_seen - err0 != 2) begin failures++; $display("FAIL bad_len_err: got %0d pulses want 2", err_seen - err0); end
        checks++;
        if (acc_cyc.size() != 1) begin failures++; $display("FAIL bad_len_beats: got %0d want 1", acc_cyc.size()); end
        checks++;
        if (pkt_cnt !== 32'(exp_pkt)) begin failures++; $display("FAIL bad_len_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); end
    endtask

    task automatic test_max_len;
        bit ok;
        int err0;
        err0 = err_seen;
        queue_pkt(9600);
        wait_drain(4000, 0, ok);
        exp_pkt++;
        checks++;
        if (!ok) begin failures++; $display("FAIL max_len_timeout: got %0d beats left want 0", exp_q.size()); end
        checks++;
        if (err_seen != err0) begin failures++; $display("FAIL max_len_err: got %0d pulses want 0", err_seen - err0); end
        checks++;
        if (pkt_cnt !== 32'(exp_pkt)) begin failures++; $display("FAIL max_len_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); end
    endtask

    task automatic test_backpressure;
        bit ok;
        int s0;
        s0 = stalls;
        queue_pkt(32);
        wait_drain(300, 1, ok);
        exp_pkt++;
        checks++;
        if (!ok) begin failures++; $display("FAIL backpressure_timeout: got %0d beats left want 0", exp_q.size()); end
        checks++;
        if (stalls - s0 < 2) begin failures++; $display("FAIL backpressure_stalls: got %0d want >=2", stalls - s0); end
        checks++;
        if (pkt_cnt !== 32'(exp_pkt)) begin failures++; $display("FAIL backpressure_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); end
    endtask

    task automatic test_starve;
        bit ok;
        int want_left;
        build_pkt(96);
        push_desc(96);
        push_words(0, 0);
        tx_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
`ifdef X2C_GBX_STORE_FWD_EN
        want_left = 12;
`else
        want_left = 8;
`endif
        checks++;
        if (exp_q.size() != want_left) begin
            failures++;
            $display("FAIL starve_beats_left: got %0d want %0d", exp_q.size(), want_left);
        end
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL starve_valid: got %b want 0", tx_valid); end
        push_words(1, 2);
        wait_drain(300, 0, ok);
        exp_pkt++;
        checks++;
        if (!ok) begin failures++; $display("FAIL starve_timeout: got %0d beats left want 0", exp_q.size()); end
        checks++;
        if (pkt_cnt !== 32'(exp_pkt)) begin failures++; $display("FAIL starve_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit found;
        found = 1'b0;
        queue_pkt(64);
        tx_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 6 && tx_valid) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL reset_mid_reach: got %0d beats left want 6 with valid", exp_q.size()); end
        reset_ = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_mid_valid: got %b want 0", tx_valid); end
        checks++;
        if (fifo_rdreq !== 1'b0) begin failures++; $display("FAIL reset_mid_rdreq: got %b want 0", fifo_rdreq); end
        checks++;
        if (pkt_cnt !== 32'd0) begin failures++; $display("FAIL reset_mid_pkt_cnt: got %0d want 0", pkt_cnt); end
        exp_q.delete();
        exp_pkt = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_ = 1'b1;
        queue_pkt(16);
        wait_drain(300, 0, ok);
        exp_pkt++;
        checks++;
        if (!ok) begin failures++; $display("FAIL reset_mid_resume: got %0d beats left want 0", exp_q.size()); end
        checks++;
        if (pkt_cnt !== 32'(exp_pkt)) begin failures++; $display("FAIL reset_mid_pkt_after: got %0d want %0d", pkt_cnt, exp_pkt); end
    endtask

    task automatic test_random;
        bit ok;
        int err0;
        int want_err;
        int len;
        int r;
        err0 = err_seen;
        want_err = 0;
        for (int p = 0; p < 10; p++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                push_desc(0);
                want_err++;
            end else if (r == 1) begin
                push_desc(9601 + $urandom_range(0, 1000));
                want_err++;
            end else begin
                len = $urandom_range(1, 200);
                queue_pkt(len);
                exp_pkt++;
            end
        end
        wait_drain(5000, 2, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL random_timeout: got %0d beats left want 0", exp_q.size()); end
        checks++;
        if (err_seen - err0 != want_err) begin
            failures++;
            $display("FAIL random_err: got %0d pulses want %0d", err_seen - err0, want_err);
        end
        checks++;
        if (pkt_cnt !== 32'(exp_pkt)) begin failures++; $display("FAIL random_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_short_last();
        test_bad_len();
        test_max_len();
        test_backpressure();
        test_starve();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/x2c_fifo_rd_gbx.md
Name: x2c_fifo_rd_gbx

Overview:
- Drain stage directly downstream of the 1024x256 x2c data FIFO.
- Pops 256-bit words from the FIFO's read side (standard-read, non-FWFT) and serialises each word into four 64-bit beats for the MAC TX datapath.
- Adds packet framing (sop/eop/mod) from a one-word descriptor that precedes each packet in the FIFO.
- Stalls cleanly on downstream backpressure.

Parameters:
- MAX_LEN, 16'd9600: largest legal payload byte length; larger lengths are rejected.
- PTR, 10: FIFO pointer width; fifo_usedw is PTR+1 bits.

Ports:
- clk  in  1  single clock; FIFO read side and TX side both run on it.
- reset_  in  1  asynchronous assert, active-low reset.
- fifo_rdreq  out  1  FIFO read request; fifo_q is valid the cycle after.
- fifo_q  in  256  FIFO read data.
- fifo_empty  in  1  FIFO empty.
- fifo_usedw  in  PTR+1  FIFO occupancy in words.
- tx_data  out  64  beat data; lane 0 = fifo_q[63:0] goes first.
- tx_valid  out  1  beat valid.
- tx_ready  in  1  downstream accept.
- tx_sop  out  1  first beat of packet.
- tx_eop  out  1  last beat of packet.
- tx_mod  out  3  valid bytes in the eop beat; 0 means 8. Don't-care when tx_eop=0.
- err_len  out  1  one-cycle pulse when a descriptor is rejected.
- pkt_cnt  out  32  packets fully sent; wraps.

Behaviour:
- Reset (async, reset_=0):
  - All outputs 0.
  - FSM to IDLE; counters and holding register cleared.
  - A packet in flight is abandoned. The FIFO is cleared by its own reset, tied to the same source.
- Descriptor word format: bits[15:0] = payload byte length L; bits[255:16] are ignored.
- Payload: ceil(L/32) words follow the descriptor, packed from byte 0 at bit 0.
- FSM:
  - IDLE: when !fifo_empty, assert fifo_rdreq for 1 cycle, go to HDR.
  - HDR: capture L = fifo_q[15:0].
    - L==0 or L>MAX_LEN: pulse err_len, discard the descriptor only, go to IDLE.
    - Otherwise: words_left = ceil(L/32), bytes_left = L, go to RDW (or SFW when the optional feature is enabled).
  - RDW: when !fifo_empty, assert fifo_rdreq, go to LOAD. If empty, stay in RDW.
  - LOAD: latch fifo_q into the 256-bit holding register; words_left--; lane=0; go to SEND.
  - SEND:
    - tx_valid=1; tx_data = hold[64*lane +: 64].
    - tx_sop=1 on the first beat of the packet only.
    - Last beat of packet: bytes_left<=8 → tx_eop=1, tx_mod = bytes_left[2:0].
    - On tx_valid&&tx_ready: bytes_left -= 8 (saturate at 0), lane++.
    - Exit after the eop beat: pkt_cnt++, go to IDLE.
    - Exit after lane 3 is accepted without eop: go to RDW.
    - Early read: in the cycle lane 3 is accepted and !fifo_empty, assert fifo_rdreq and go directly to LOAD. This gives one bubble per 256-bit word (steady state 4 beats per 5 cycles).
- Handshake:
  - tx_data, tx_sop, tx_eop and tx_mod hold stable while tx_valid=1 and tx_ready=0.
  - tx_valid never drops before acceptance.
- fifo_rdreq is never asserted while fifo_empty=1. At most one read is outstanding.
- A short last word (L not a multiple of 32) emits only ceil(bytes_left/8) beats. Unused lanes are never emitted.
- Words remain in the FIFO if it starves mid-packet. The FSM waits in RDW with tx_valid=0; no timeout.
- tx_mod arithmetic: bytes_left is 16 bits unsigned. tx_mod = bytes_left[2:0] when bytes_left<=8 (8 maps to 0).

Optional Feature:
- Macro: X2C_GBX_STORE_FWD_EN.
- When defined: HDR goes to an SFW state. SFW holds until fifo_usedw >= ceil(L/32), then goes to RDW. The packet is then never starved mid-flight.
- When undefined: no SFW state; cut-through as described above.

Decomposition:
- Package x2c_gbx_pkg holds:
  - FSM state encoding (IDLE, HDR, SFW, RDW, LOAD, SEND).
  - Descriptor field constants: LEN_LSB=0, LEN_MSB=15.
  - Constants BEAT_W=64, WORD_W=256, LANES=4.
- One natural sub-module: x2c_gbx_lane_mux. It is the holding register plus 4:1 lane select plus sop/eop/mod generation. The FSM and counters stay in the top.

Test Plan:
- Descriptor L=64, two payload words, tx_ready=1 → 8 beats; sop on beat 0; eop on beat 7 with mod=0; pkt_cnt=1; one bubble between beats 3 and 4.
- L=45 → 6 beats; eop on beat 5 with mod=5; lanes 2-3 of word 1 never emitted; next descriptor is read next.
- L=0, then L=9601 → err_len pulses twice; no tx_valid; pkt_cnt unchanged; following valid packet L=8 → 1 beat with sop=eop=1, mod=0.
- L=32, tx_ready toggling 1-0-0-1 → tx_data/sop/eop held stable while stalled; beats in order q[63:0], q[127:64], q[191:128], q[255:192].
- FIFO empties after word 1 of L=96 → FSM waits in RDW with tx_valid=0 and no rdreq; resumes when a word arrives. With X2C_GBX_STORE_FWD_EN, no beat is sent until usedw>=3.
- reset_ low mid-SEND (lane 2) → tx_valid, rdreq and pkt_cnt are 0 immediately; after release, a new descriptor is processed normally.
